// File: rtl/des_f_pkg.sv
// DES round-function tables: expansion E, permutation P and the eight S-boxes.
// Table entries use DES numbering (bit 1 = MSB); S-box rows are packed col 0 first.
package des_f_pkg;

  localparam int unsigned R_W     = 32;
  localparam int unsigned K_W     = 48;
  localparam int unsigned S_IN_W  = 6;
  localparam int unsigned S_OUT_W = 4;
  localparam int unsigned N_BOX   = 8;
  localparam int unsigned TBL_W   = 256;

  localparam int unsigned E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int unsigned P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each entry: rows 0..3 of one box, 16 nibbles per row, column 0 in the MSB.
  localparam logic [TBL_W-1:0] SBOX_TBL [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

endpackage

// File: rtl/des_sbox.sv
// One combinational DES S-box lookup; box_idx selects S1 (0) .. S8 (7).
module des_sbox
  import des_f_pkg::*;
(
  input  logic [2:0]         box_idx,
  input  logic [S_IN_W-1:0]  din,
  output logic [S_OUT_W-1:0] dout_c
);

  logic [5:0]       sel_c;
  logic [TBL_W-1:0] tbl_c;

  // Entry (row*16 + col) sits at nibble offset 63-sel from the LSB, i.e. bit 4*(~sel).
  always_comb begin
    sel_c  = {din[5], din[0], din[4:1]};
    tbl_c  = SBOX_TBL[box_idx];
    dout_c = tbl_c[{~sel_c, 2'b00} +: 4];
  end

endmodule

// File: rtl/des_f_function.sv
// Registered DES round function f(R, K) = P(S(E(R) xor K)), one result per cycle.
module des_f_function
  import des_f_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [R_W-1:0] r_in,
  input  logic [K_W-1:0] subkey,
  output logic           out_valid,
  output logic [R_W-1:0] f_out,
  output logic [R_W-1:0] sbox_out
);

  logic [K_W-1:0]     e_c;
  logic [K_W-1:0]     x_c;
  logic [S_OUT_W-1:0] sbox_nib_c [N_BOX];
  logic [R_W-1:0]     sbox_c;
  logic [R_W-1:0]     p_c;

  logic           out_valid_q, out_valid_d;
  logic [R_W-1:0] f_out_q, f_out_d;
  logic [R_W-1:0] sbox_out_q, sbox_out_d;

  // Expansion and key mix; DES bit n of a w-bit vector is Verilog bit w-n.
  always_comb begin
    e_c = '0;
    for (int i = 0; i < 48; i++) begin
      e_c[6'(47 - i)] = r_in[5'(32 - E_TBL[i])];
    end
    x_c = e_c ^ subkey;
  end

  for (genvar g = 0; g < N_BOX; g++) begin : g_sbox
    des_sbox u_sbox (
      .box_idx (3'(g)),
      .din     (x_c[47-6*g -: 6]),
      .dout_c  (sbox_nib_c[g])
    );
  end

  // S1 lands in the top nibble, S8 in the bottom; then the P permutation.
  always_comb begin
    sbox_c = '0;
    for (int i = 0; i < 8; i++) begin
      sbox_c[5'(28 - 4*i) +: 4] = sbox_nib_c[i];
    end
    p_c = '0;
    for (int i = 0; i < 32; i++) begin
      p_c[5'(31 - i)] = sbox_c[5'(32 - P_TBL[i])];
    end
  end

  always_comb begin
    out_valid_d = in_valid;
    f_out_d     = f_out_q;
    sbox_out_d  = sbox_out_q;
    if (in_valid) begin
      f_out_d    = p_c;
      sbox_out_d = sbox_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      f_out_q     <= '0;
      sbox_out_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      f_out_q     <= f_out_d;
      sbox_out_q  <= sbox_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign f_out     = f_out_q;
  assign sbox_out  = sbox_out_q;

endmodule

// File: tb/tb_des_f_function.sv
// Directed bench for des_f_function with hand-computed FIPS 46-3 vectors.
module tb_des_f_function;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] r_in;
  logic [47:0] subkey;
  logic        out_valid;
  logic [31:0] f_out;
  logic [31:0] sbox_out;

  int checks = 0;
  int errors = 0;

  des_f_function dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .r_in      (r_in),
    .subkey    (subkey),
    .out_valid (out_valid),
    .f_out     (f_out),
    .sbox_out  (sbox_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // S-box outputs for inputs 000000, 111111, 100001 (row0/col0, row3/col15, row3/col0).
  int exp_sweep [8][3] = '{
    '{14, 13, 15}, '{15,  9, 13}, '{10, 12,  1}, '{ 7, 14,  3},
    '{ 2,  3, 11}, '{12, 13,  4}, '{ 4, 12,  6}, '{13, 11,  2}
  };
  logic [5:0] sweep_in [3] = '{6'b000000, 6'b111111, 6'b100001};
  logic [31:0] zero_sbox = 32'hEFA72C4D;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [47:0] k);
    in_valid = v;
    r_in     = r;
    subkey   = k;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_sb;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 48'h0);
    #2;
    check("reset_out_valid", 48'(out_valid), 48'h0);
    check("reset_f_out",     48'(f_out),     48'h0);
    check("reset_sbox_out",  48'(sbox_out),  48'h0);
    #5 rst_n = 1'b1;

    // Zero vector
    tick();
    drive(1'b1, 32'h0, 48'h0);
    tick();
    check("zero_sbox",  48'(sbox_out),  48'hEFA72C4D);
    check("zero_f",     48'(f_out),     48'hD8D8DBBC);
    check("zero_valid", 48'(out_valid), 48'h1);

    // Textbook round 1
    drive(1'b1, 32'hF0AAF0AA, 48'h1B02EFFC7072);
    #1;
    check("tb_expand", dut.e_c, 48'h7A15557A1555);
    check("tb_xor",    dut.x_c, 48'h6117BA866527);
    tick();
    check("tb_sbox",  48'(sbox_out),  48'h5C82B597);
    check("tb_f",     48'(f_out),     48'h234AA9BB);
    check("tb_valid", 48'(out_valid), 48'h1);

    // Hold with in_valid low; expansion edges exercised meanwhile
    drive(1'b0, 32'h00000001, 48'h0);
    #1 check("exp_lsb", dut.e_c, 48'h800000000002);
    tick();
    check("hold1_valid", 48'(out_valid), 48'h0);
    check("hold1_f",     48'(f_out),     48'h234AA9BB);
    drive(1'b0, 32'hFFFFFFFF, 48'h0);
    #1 check("exp_ones", dut.e_c, 48'hFFFFFFFFFFFF);
    tick();
    check("hold2_valid", 48'(out_valid), 48'h0);
    check("hold2_f",     48'(f_out),     48'h234AA9BB);
    tick();
    check("hold3_valid", 48'(out_valid), 48'h0);
    check("hold3_f",     48'(f_out),     48'h234AA9BB);
    check("hold3_sbox",  48'(sbox_out),  48'h5C82B597);

    // Back-to-back valid vectors
    drive(1'b1, 32'h0, 48'h0);
    tick();
    check("b2b0_f",     48'(f_out),     48'hD8D8DBBC);
    check("b2b0_valid", 48'(out_valid), 48'h1);
    drive(1'b1, 32'hF0AAF0AA, 48'h1B02EFFC7072);
    tick();
    check("b2b1_f",     48'(f_out),     48'h234AA9BB);
    check("b2b1_valid", 48'(out_valid), 48'h1);

    // Asynchronous reset between edges with nonzero outputs
    drive(1'b0, 32'h0, 48'h0);
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid", 48'(out_valid), 48'h0);
    check("areset_f",     48'(f_out),     48'h0);
    check("areset_sbox",  48'(sbox_out),  48'h0);
    #3 rst_n = 1'b1;
    tick();
    check("post_reset_idle_f", 48'(f_out), 48'h0);
    drive(1'b1, 32'hF0AAF0AA, 48'h1B02EFFC7072);
    tick();
    check("post_reset_f",     48'(f_out),     48'h234AA9BB);
    check("post_reset_valid", 48'(out_valid), 48'h1);

    // S-box sweep: other boxes see 000000 and return their row0/col0 entry
    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < 3; j++) begin
        exp_sb = zero_sbox;
        exp_sb[28-4*b +: 4] = 4'(exp_sweep[b][j]);
        drive(1'b1, 32'h0, {sweep_in[j], 42'h0} >> (6*b));
        tick();
        check($sformatf("sweep_s%0d_%b", b+1, sweep_in[j]), 48'(sbox_out), 48'(exp_sb));
      end
    end

    drive(1'b0, 32'h0, 48'h0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
